// File: rtl/axi_mem_slave.sv
// AXI4 slave bridging INCR bursts onto a single-port core-style memory (req/gnt/rvalid).
// One transaction in flight, one memory access at a time; 32-bit data only.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]                  aw_len_i,

    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                        w_last_i,

    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]                  b_resp_o,

    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]                  ar_len_i,

    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,

    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                        mem_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int WordW = AXI_ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_DATA
    } state_t;

    state_t                      state_q, state_d;
    logic                        prio_rd_q, prio_rd_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [WordW-1:0]            addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [7:0]                  beat_q, beat_d;
    logic                        err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0]   rbuf_q, rbuf_d;

    logic aw_win;
    logic ar_win;
    logic last_beat;
    logic unused_addr_lsbs;

    // Only word addresses are kept; the byte offset of AW/AR is dropped.
    assign unused_addr_lsbs = ^{aw_addr_i[1:0], ar_addr_i[1:0]};
    assign last_beat        = (beat_q == len_q);
    assign mem_addr_o       = {addr_q + WordW'(beat_q), 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            rbuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            prio_rd_q <= prio_rd_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            rbuf_q    <= rbuf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_rd_d   = prio_rd_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        err_d       = err_q;
        rbuf_d      = rbuf_q;
        aw_win      = 1'b0;
        ar_win      = 1'b0;
        aw_ready_o  = 1'b0;
        ar_ready_o  = 1'b0;
        w_ready_o   = 1'b0;
        b_valid_o   = 1'b0;
        b_id_o      = '0;
        b_resp_o    = 2'b00;
        r_valid_o   = 1'b0;
        r_id_o      = '0;
        r_data_o    = '0;
        r_resp_o    = 2'b00;
        r_last_o    = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;

        case (state_q)
            IDLE: begin
                // Readies are gated by reset so nothing is accepted while rst_i is held.
                if (!rst_i) begin
                    aw_win = aw_valid_i && (!ar_valid_i || !prio_rd_q);
                    ar_win = ar_valid_i && !aw_win;
                end
                aw_ready_o = aw_win;
                ar_ready_o = ar_win;
                // The priority only flips when both channels actually competed for the grant.
                if (aw_win && ar_valid_i || ar_win && aw_valid_i) begin
                    prio_rd_d = !prio_rd_q;
                end
                if (aw_win) begin
                    id_d    = aw_id_i;
                    addr_d  = aw_addr_i[AXI_ADDR_WIDTH-1:2];
                    len_d   = aw_len_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = WR_DATA;
                end else if (ar_win) begin
                    id_d    = ar_id_i;
                    addr_d  = ar_addr_i[AXI_ADDR_WIDTH-1:2];
                    len_d   = ar_len_i;
                    beat_d  = '0;
                    state_d = RD_REQ;
                end
            end

            WR_DATA: begin
                mem_req_o   = w_valid_i;
                mem_we_o    = 1'b1;
                mem_be_o    = w_strb_i;
                mem_wdata_o = w_data_i;
                w_ready_o   = mem_gnt_i;
                if (w_valid_i && mem_gnt_i) begin
                    if (w_last_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            WR_RESP: begin
                b_valid_o = 1'b1;
                b_id_o    = id_q;
                b_resp_o  = err_q ? 2'b10 : 2'b00;
                if (b_ready_i) begin
                    state_d = IDLE;
                end
            end

            RD_REQ: begin
                mem_req_o = 1'b1;
                mem_be_o  = '1;
                if (mem_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (mem_rvalid_i) begin
                    rbuf_d  = mem_rdata_i;
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                r_valid_o = 1'b1;
                r_id_o    = id_q;
                r_data_o  = rbuf_q;
                r_last_o  = last_beat;
                if (r_ready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = RD_REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
